fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the pipelined CPU. Owns the program counter, drives it to the
//  asynchronous instruction ROM, and captures the returned word into the IF/ID pipeline register.
//  Handles stall, flush and branch/jump redirect from later stages, and a HALT state on a halt opcode.
// PARAMETERS
//  DATA_WIDTH   32           PC / instruction width
//  RESET_PC     32'h0        PC value loaded on reset
//  HALT_INSTR   32'h00000073 opcode that stops fetching (ecall)
//  NOP_INSTR    32'h00000013 bubble word placed in IF/ID (addi x0,x0,0)
//  COUNT_WIDTH  16           width of the fetched-instruction counter
// PORTS
//  clk            in   1            single clock; all state updates on rising edge
//  rst            in   1            synchronous, active-low reset
//  stall_i        in   1            hazard stall: hold PC and IF/ID contents
//  flush_i        in   1            load bubble into IF/ID (does not move PC by itself)
//  redirect_i     in   1            taken branch/jump: next PC = redirect_pc_i
//  redirect_pc_i  in   DATA_WIDTH   redirect target
//  pc_o           out  DATA_WIDTH   current fetch PC, to ROM address input
//  instr_i        in   DATA_WIDTH   ROM output for pc_o (combinational, same cycle)
//  instr_d_o      out  DATA_WIDTH   IF/ID instruction
//  pc_d_o         out  DATA_WIDTH   IF/ID PC of that instruction
//  pc_plus4_d_o   out  DATA_WIDTH   IF/ID PC+4 (link value)
//  valid_d_o      out  1            IF/ID holds a real instruction
//  halted_o       out  1            FSM is in HALT
//  fetch_count_o  out  COUNT_WIDTH  valid instructions captured into IF/ID since reset
// BEHAVIOUR
//  Reset (rst==0 at edge): pc_o=RESET_PC, instr_d_o=NOP_INSTR, pc_d_o=0, pc_plus4_d_o=0,
//   valid_d_o=0, halted_o=0, fetch_count_o=0, FSM=RUN. Reset mid-operation discards everything.
//  Latency: word for PC p appears on instr_d_o one cycle after pc_o==p; ROM read is combinational.
//  FSM states RUN, HALT. Per-edge priority (highest first): reset > redirect > stall > normal.
//  RUN, redirect_i=1: pc_o <= {redirect_pc_i[31:2],2'b00} (low bits forced 0); IF/ID <= bubble;
//   stall_i ignored that cycle.
//  RUN, flush_i=1, no redirect: IF/ID <= bubble; PC advances +4 unless stall_i=1 (then holds).
//  RUN, stall_i=1, no redirect/flush: pc_o and IF/ID hold; counter holds.
//  RUN, normal: IF/ID <= {instr_i, pc_o, pc_o+4, valid=1}; pc_o <= pc_o+4.
//   If instr_i==HALT_INSTR on a normal capture: it is captured (valid=1), FSM -> HALT, pc_o holds.
//  HALT: pc_o holds; IF/ID <= bubble every cycle; halted_o=1; stall_i/flush_i ignored.
//   redirect_i in HALT -> RUN at redirected PC (halt was speculative); only exit besides reset.
//  Bubble = {NOP_INSTR, pc 0, pc+4 0, valid 0}.
//  fetch_count_o +1 on each edge that loads valid=1 into IF/ID; saturates at all-ones.
//  PC arithmetic is modulo 2^DATA_WIDTH: 32'hFFFFFFFC + 4 wraps to 0, no flag.
//  Simultaneous flush_i and stall_i: bubble loaded, PC holds. Simultaneous redirect and halt
//   opcode on instr_i: redirect wins, halt word is not captured, FSM stays RUN.
// TESTING
//  1 Reset 3 cycles, release, ROM[0..2]=A,B,C -> pc_o 0,4,8,C; instr_d_o A,B,C from cycle 1; count=3.
//  2 Stall at pc_o=8 for 2 cycles -> pc_o stays 8, IF/ID keeps word@4, count unchanged, then resumes.
//  3 redirect_i=1 with target 32'h43 while stall_i=1 -> pc_o=32'h40 next cycle, valid_d_o=0.
//  4 ROM word @0xC = 32'h00000073 -> captured valid, halted_o=1, pc_o frozen at 0xC, then bubbles;
//    redirect to 0x20 -> halted_o=0, fetch resumes at 0x20.
//  5 flush_i and stall_i together at pc_o=0x10 -> instr_d_o=32'h13, valid_d_o=0, pc_o stays 0x10.
//  6 rst=0 mid-run at pc_o=0x24 -> next cycle pc_o=0, valid_d_o=0, fetch_count_o=0, halted_o=0;
//    COUNT_WIDTH=2 run of 5 valid fetches -> count saturates at 3.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control and redirect from later stages, ROM address/data, IF/ID outputs.
interface fetch_stage_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 16
);
  logic                   stall_i;
  logic                   flush_i;
  logic                   redirect_i;
  logic [DATA_WIDTH-1:0]  redirect_pc_i;
  logic [DATA_WIDTH-1:0]  pc_o;
  logic [DATA_WIDTH-1:0]  instr_i;
  logic [DATA_WIDTH-1:0]  instr_d_o;
  logic [DATA_WIDTH-1:0]  pc_d_o;
  logic [DATA_WIDTH-1:0]  pc_plus4_d_o;
  logic                   valid_d_o;
  logic                   halted_o;
  logic [COUNT_WIDTH-1:0] fetch_count_o;

  modport master (
    output stall_i, flush_i, redirect_i, redirect_pc_i, instr_i,
    input  pc_o, instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o, halted_o, fetch_count_o
  );

  modport slave (
    input  stall_i, flush_i, redirect_i, redirect_pc_i, instr_i,
    output pc_o, instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o, halted_o, fetch_count_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID capture, stall/flush/redirect handling and HALT on ecall.
module fetch_stage #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'h0000_0073,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_pc;
  logic [DATA_WIDTH-1:0]  r_instr_d;
  logic [DATA_WIDTH-1:0]  r_pc_d;
  logic [DATA_WIDTH-1:0]  r_pc_plus4_d;
  logic                   r_valid_d;
  logic                   r_halted;
  logic [COUNT_WIDTH-1:0] r_count;

  logic [DATA_WIDTH-1:0]  w_pc_plus4;
  logic [DATA_WIDTH-1:0]  w_redirect_pc;
  logic [COUNT_WIDTH-1:0] w_count_inc;

  // Wraps modulo 2^DATA_WIDTH; redirect targets are forced word aligned.
  assign w_pc_plus4    = r_pc + DATA_WIDTH'(4);
  assign w_redirect_pc = bus.redirect_pc_i & ~DATA_WIDTH'(3);
  assign w_count_inc   = (r_count == '1) ? r_count : r_count + COUNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
      r_halted     <= 1'b0;
      r_count      <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.redirect_i) begin
            r_pc         <= w_redirect_pc;
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
          end else if (bus.flush_i) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
            if (!bus.stall_i) r_pc <= w_pc_plus4;
          end else if (!bus.stall_i) begin
            r_instr_d    <= bus.instr_i;
            r_pc_d       <= r_pc;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b1;
            r_count      <= w_count_inc;
            // The halt word itself is delivered downstream; the PC parks on it.
            if (bus.instr_i == HALT_INSTR) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc <= w_pc_plus4;
            end
          end
        end
        ST_HALT: begin
          r_instr_d    <= NOP_INSTR;
          r_pc_d       <= '0;
          r_pc_plus4_d <= '0;
          r_valid_d    <= 1'b0;
          if (bus.redirect_i) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
            r_pc     <= w_redirect_pc;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.pc_o          = r_pc;
  assign bus.instr_d_o     = r_instr_d;
  assign bus.pc_d_o        = r_pc_d;
  assign bus.pc_plus4_d_o  = r_pc_plus4_d;
  assign bus.valid_d_o     = r_valid_d;
  assign bus.halted_o      = r_halted;
  assign bus.fetch_count_o = r_count;

endmodule
